// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that lets N requesters share one
// combinational ALU. One operation is in flight at a time: IDLE accepts,
// EXEC captures the ALU result, and RESP holds the tagged result until the
// consumer takes it.
module alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*3-1:0]     req_sel,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_sel,
  input  logic [WIDTH-1:0]       alu_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_err,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ID_W-1:0]   last_grant_reg;
  logic [WIDTH-1:0]  alu_a_reg;
  logic [WIDTH-1:0]  alu_b_reg;
  logic [2:0]        alu_sel_reg;
  logic              rsp_valid_reg;
  logic [WIDTH-1:0]  rsp_data_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic              rsp_err_reg;

  logic              found;
  logic [ID_W-1:0]   winner;
  logic              accept;
  logic [WIDTH-1:0]  win_a;
  logic [WIDTH-1:0]  win_b;
  logic [2:0]        win_sel;
  logic              sel_illegal;

  // Per-requester views of the packed operand buses.
  logic [WIDTH-1:0]  a_arr   [N_REQ];
  logic [WIDTH-1:0]  b_arr   [N_REQ];
  logic [2:0]        sel_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr[gi]   = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi]   = req_b[gi*WIDTH +: WIDTH];
    assign sel_arr[gi] = req_sel[gi*3 +: 3];
  end

  // Round-robin search: first look above last_grant, then wrap to the
  // indices at or below it, so the last winner has the lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i] && (i > int'(last_grant_reg))) begin
        found  = 1'b1;
        winner = i[ID_W-1:0];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i] && (i <= int'(last_grant_reg))) begin
        found  = 1'b1;
        winner = i[ID_W-1:0];
      end
    end
  end

  // Select the winning requester's operands and opcode.
  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == i[ID_W-1:0]) begin
        win_a   = a_arr[i];
        win_b   = b_arr[i];
        win_sel = sel_arr[i];
      end
    end
  end

  // Opcodes 101..111 have no ALU function behind them.
  assign sel_illegal = (alu_sel_reg > 3'd4);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and the combinational grant to the winner.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          accept     = 1'b1;
          state_next = EXEC;
          for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (winner == i[ID_W-1:0]);
          end
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch the granted request, capture the ALU result, and
  // retire the response on handshake. ALU drive registers are never
  // cleared after an operation so the ALU inputs stay quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= ID_W'(N_REQ - 1);
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_sel_reg    <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_id_reg     <= '0;
      rsp_err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        alu_a_reg      <= win_a;
        alu_b_reg      <= win_b;
        alu_sel_reg    <= win_sel;
        last_grant_reg <= winner;
        rsp_id_reg     <= winner;
      end
      if (state_reg == EXEC) begin
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= sel_illegal ? '0 : alu_out;
        rsp_err_reg   <= sel_illegal;
      end
      if ((state_reg == RESP) && rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_sel   = alu_sel_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_err   = rsp_err_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU
// attached to the alu_* ports. Expected responses come from constant
// tables and are queued when each request is driven or granted.
module tb_alu_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N*3-1:0]   req_sel;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [2:0]       alu_sel;
  logic [W-1:0]     alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_data;
  logic [IW-1:0]    rsp_id;
  logic             rsp_err;
  logic             busy;

  alu_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural shared ALU; illegal codes return all ones so a design that
  // forwards alu_out instead of forcing zero is visible.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      3'b100:  alu_out = ~alu_a;
      default: alu_out = 4'hF;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] s);
    req_valid[i]       = 1'b1;
    req_a[i*W +: W]    = a;
    req_b[i*W +: W]    = b;
    req_sel[i*3 +: 3]  = s;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rsp_ready = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for any grant; returns just after the accepting edge.
  task automatic wait_grant(output logic [N-1:0] g, output int acc, output bit ok);
    ok  = 1'b0;
    g   = '0;
    acc = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if (req_ready !== '0) begin
        ok  = 1'b1;
        g   = req_ready;
        acc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for rsp_valid; returns mid-cycle with the response visible.
  task automatic wait_rsp(output int rc, output bit ok);
    ok = 1'b0;
    rc = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        rc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (ok) $display("rsp id=%0d data=%b err=%b at cycle %0d", rsp_id, rsp_data, rsp_err, rc);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    rsp_ready = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_id, rsp_err, busy} !== 24'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required 000000",
               {req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_id, rsp_err, busy});
    end
    rst       = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({req_ready, busy, rsp_valid} !== 6'd0) begin
      failures++;
      $display("FAIL idle_no_request: got ready=%b busy=%b valid=%b, required all 0",
               req_ready, busy, rsp_valid);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] g;
    int acc, rc;
    bit ok, okr;
    exp_t e;
    set_req(0, 4'b0101, 4'b0011, OP_ADD);
    exp_q.push_back('{id: 2'd0, data: 4'b1000, err: 1'b0});
    wait_grant(g, acc, ok);
    req_valid[0] = 1'b0;
    $display("grant %b at cycle %0d", g, acc);
    checks++;
    if (!ok || g !== 4'b0001) begin
      failures++;
      $display("FAIL basic_grant: got ok=%0d ready=%b, required ready=0001", ok, g);
    end
    checks++;
    if ({busy, alu_a, alu_b, alu_sel} !== {1'b1, 4'b0101, 4'b0011, OP_ADD}) begin
      failures++;
      $display("FAIL basic_alu_drive: got busy=%b a=%b b=%b sel=%b, required 1 0101 0011 000",
               busy, alu_a, alu_b, alu_sel);
    end
    wait_rsp(rc, okr);
    checks++;
    if (!okr || (rc - acc) != 2) begin
      failures++;
      $display("FAIL basic_latency: got ok=%0d latency=%0d, required 2", okr, rc - acc);
    end
    e = exp_q.pop_front();
    checks++;
    if ({rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
      failures++;
      $display("FAIL basic_rsp: got id=%0d data=%b err=%b, required id=%0d data=%b err=%b",
               rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
    end
  endtask

  task automatic test_all_ops();
    logic [W-1:0] ta [5] = '{4'b0101, 4'b1100, 4'b1100, 4'b1100, 4'b1111};
    logic [W-1:0] tb [5] = '{4'b0011, 4'b1010, 4'b1010, 4'b0101, 4'b0001};
    logic [2:0]   ts [5] = '{OP_SUB, OP_AND, OP_OR, OP_NOT, OP_ADD};
    logic [W-1:0] tr [5] = '{4'b0010, 4'b1000, 4'b1110, 4'b0011, 4'b0000};
    logic [N-1:0] g;
    int acc, rc;
    bit ok, okr;
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      set_req(1, ta[k], tb[k], ts[k]);
      exp_q.push_back('{id: 2'd1, data: tr[k], err: 1'b0});
      wait_grant(g, acc, ok);
      req_valid[1] = 1'b0;
      checks++;
      if (!ok || g !== 4'b0010) begin
        failures++;
        $display("FAIL op%0d_grant: got ok=%0d ready=%b, required 0010", k, ok, g);
      end
      wait_rsp(rc, okr);
      e = exp_q.pop_front();
      checks++;
      if (!okr || {rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
        failures++;
        $display("FAIL op%0d_rsp: got ok=%0d id=%0d data=%b err=%b, required id=%0d data=%b err=%b",
                 k, okr, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] ra [N] = '{4'h1, 4'h7, 4'hC, 4'h8};
    logic [W-1:0] rb [N] = '{4'h2, 4'h2, 4'h6, 4'h1};
    logic [2:0]   rs [N] = '{OP_ADD, OP_SUB, OP_AND, OP_OR};
    logic [W-1:0] rr [N] = '{4'h3, 4'h5, 4'h4, 4'h9};
    int order [6] = '{0, 1, 2, 3, 0, 1};
    logic [N-1:0] g;
    logic [N-1:0] g_exp;
    int acc, prev, rc;
    bit ok, okr;
    exp_t e;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, ra[i], rb[i], rs[i]);
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_grant(g, acc, ok);
      g_exp = '0;
      g_exp[order[k]] = 1'b1;
      exp_q.push_back('{id: order[k][IW-1:0], data: rr[order[k]], err: 1'b0});
      $display("grant %b at cycle %0d", g, acc);
      checks++;
      if (!ok || g !== g_exp) begin
        failures++;
        $display("FAIL rr%0d_grant: got ok=%0d ready=%b, required %b", k, ok, g, g_exp);
      end
      if (k > 0) begin
        checks++;
        if (acc - prev != 3) begin
          failures++;
          $display("FAIL rr%0d_spacing: got %0d cycles, required 3", k, acc - prev);
        end
      end
      prev = acc;
      wait_rsp(rc, okr);
      e = exp_q.pop_front();
      checks++;
      if (!okr || {rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
        failures++;
        $display("FAIL rr%0d_rsp: got ok=%0d id=%0d data=%b err=%b, required id=%0d data=%b err=%b",
                 k, okr, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
      end
    end
    clear_inputs();
  endtask

  task automatic test_back_pressure();
    logic [N-1:0] g;
    int acc, rc, h;
    bit ok, okr;
    exp_t e;
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 4'h2, 4'h3, OP_ADD);
    exp_q.push_back('{id: 2'd0, data: 4'h5, err: 1'b0});
    wait_grant(g, acc, ok);
    req_valid[0] = 1'b0;
    set_req(2, 4'h9, 4'h6, OP_OR);
    wait_rsp(rc, okr);
    e = exp_q.pop_front();
    checks++;
    if (!okr || {rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
      failures++;
      $display("FAIL bp_first_rsp: got ok=%0d id=%0d data=%b err=%b, required id=%0d data=%b err=%b",
               okr, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_data, rsp_id, req_ready} !== {1'b1, e.data, e.id, 4'b0000}) begin
        failures++;
        $display("FAIL bp_hold%0d: got valid=%b data=%b id=%0d ready=%b, required 1 %b %0d 0000",
                 k, rsp_valid, rsp_data, rsp_id, req_ready, e.data, e.id);
      end
    end
    rsp_ready = 1'b1;
    h = cyc;
    @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, req_ready} !== {1'b0, 4'b0100}) begin
      failures++;
      $display("FAIL bp_release: got valid=%b ready=%b, required 0 0100", rsp_valid, req_ready);
    end
    wait_grant(g, acc, ok);
    req_valid[2] = 1'b0;
    exp_q.push_back('{id: 2'd2, data: 4'hF, err: 1'b0});
    checks++;
    if (!ok || g !== 4'b0100 || acc != h + 1) begin
      failures++;
      $display("FAIL bp_accept: got ok=%0d ready=%b cycle=%0d, required 0100 at %0d",
               ok, g, acc, h + 1);
    end
    wait_rsp(rc, okr);
    e = exp_q.pop_front();
    checks++;
    if (!okr || {rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
      failures++;
      $display("FAIL bp_second_rsp: got ok=%0d id=%0d data=%b err=%b, required id=%0d data=%b err=%b",
               okr, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
    end
  endtask

  task automatic test_illegal();
    logic [2:0]   ls [4] = '{3'b101, 3'b110, 3'b111, OP_AND};
    logic [W-1:0] lr [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010};
    logic         le [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [N-1:0] g;
    int acc, rc;
    bit ok, okr;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      set_req(3, 4'b0110, 4'b0011, ls[k]);
      exp_q.push_back('{id: 2'd3, data: lr[k], err: le[k]});
      wait_grant(g, acc, ok);
      req_valid[3] = 1'b0;
      wait_rsp(rc, okr);
      e = exp_q.pop_front();
      checks++;
      if (!ok || !okr || {rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
        failures++;
        $display("FAIL illegal%0d_rsp: got ok=%0d/%0d id=%0d data=%b err=%b, required id=%0d data=%b err=%b",
                 k, ok, okr, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [N-1:0] g;
    int acc, rc;
    bit ok, okr;
    exp_t e;
    set_req(1, 4'h5, 4'h5, OP_ADD);
    wait_grant(g, acc, ok);
    req_valid[1] = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_id, rsp_err, busy} !== 24'd0) begin
      failures++;
      $display("FAIL midop_async_reset: got %h, required 000000",
               {req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_id, rsp_err, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL midop_no_rsp%0d: got rsp_valid=%b, required 0", k, rsp_valid);
      end
    end
    set_req(0, 4'h1, 4'h1, OP_ADD);
    set_req(1, 4'h3, 4'h1, OP_SUB);
    wait_grant(g, acc, ok);
    clear_inputs();
    exp_q.push_back('{id: 2'd0, data: 4'h2, err: 1'b0});
    checks++;
    if (!ok || g !== 4'b0001) begin
      failures++;
      $display("FAIL midop_first_winner: got ok=%0d ready=%b, required 0001", ok, g);
    end
    wait_rsp(rc, okr);
    e = exp_q.pop_front();
    checks++;
    if (!okr || {rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
      failures++;
      $display("FAIL midop_rsp: got ok=%0d id=%0d data=%b err=%b, required id=%0d data=%b err=%b",
               okr, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  initial begin
    clear_inputs();
    rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_all_ops();
    test_round_robin();
    test_back_pressure();
    test_illegal();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
